l2c_mem_bridge: RTL and testbench

// Memory-side engine downstream of the L2 cache controller. Services inst/data dirty-writeback and replace-fill

---
 rtl/l2c_mem_bridge_if.sv | 15 +
 rtl/l2c_mem_bridge.sv | 161 ++++++++++++++++
 tb/tb_l2c_mem_bridge.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2c_mem_bridge_if.sv
// Word-serial main-memory port of the L2 memory bridge: one beat per req/ack handshake.
interface l2c_mem_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/l2c_mem_bridge.sv
// L2 memory-side engine: queues inst/data writeback and fill requests and serves them
// one line at a time as word-serial bursts on a single memory port.
module l2c_mem_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                             clk_l2,
    input  logic                             rst_n,
    input  logic                             inst_mem_dirty_req,
    input  logic                             inst_mem_replace_req,
    input  logic [ADDR_WIDTH-1:0]            inst_dirty_addr,
    input  logic [ADDR_WIDTH-1:0]            inst_replace_addr,
    input  logic [LINE_WORDS*DATA_WIDTH-1:0] inst_dirty_line,
    output logic                             inst_mem_dirty_done,
    output logic                             inst_mem_replace_done,
    input  logic                             data_mem_dirty_req,
    input  logic                             data_mem_replace_req,
    input  logic [ADDR_WIDTH-1:0]            data_dirty_addr,
    input  logic [ADDR_WIDTH-1:0]            data_replace_addr,
    input  logic [LINE_WORDS*DATA_WIDTH-1:0] data_dirty_line,
    output logic                             data_mem_dirty_done,
    output logic                             data_mem_replace_done,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] fill_line,
    l2c_mem_bridge_if.master                 mem
);
    localparam int LINE_BITS = LINE_WORDS * DATA_WIDTH;
    localparam int BEAT_W    = $clog2(LINE_WORDS);
    localparam int WORD_OFF  = $clog2(DATA_WIDTH / 8);
    localparam int LINE_OFF  = BEAT_W + WORD_OFF;
    localparam int TAG_W     = ADDR_WIDTH - LINE_OFF;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

    // Request slots are indexed {channel, is_fill}: 0 inst wb, 1 inst fill, 2 data wb, 3 data fill.
    state_t               state_reg, state_next;
    logic [3:0]           req_in, req_q_reg, pend_reg, edge_hit;
    logic [TAG_W-1:0]     addr_in  [4];
    logic [TAG_W-1:0]     addr_reg [4];
    logic [LINE_BITS-1:0] dline_reg [2];
    logic [1:0]           cur_slot_reg;
    logic                 rr_reg;
    logic [BEAT_W-1:0]    beat_reg;
    logic [LINE_BITS-1:0] rd_buf_reg, rd_buf_next;
    logic [DATA_WIDTH-1:0] wr_word [LINE_WORDS];
    logic                 inst_any, data_any, grant_ch, grant_rd, last_ack;
    logic                 addr_low_unused;

    assign req_in = {data_mem_replace_req, data_mem_dirty_req,
                     inst_mem_replace_req, inst_mem_dirty_req};
    assign addr_in[0] = inst_dirty_addr[ADDR_WIDTH-1:LINE_OFF];
    assign addr_in[1] = inst_replace_addr[ADDR_WIDTH-1:LINE_OFF];
    assign addr_in[2] = data_dirty_addr[ADDR_WIDTH-1:LINE_OFF];
    assign addr_in[3] = data_replace_addr[ADDR_WIDTH-1:LINE_OFF];
    assign addr_low_unused = ^{inst_dirty_addr[LINE_OFF-1:0], inst_replace_addr[LINE_OFF-1:0],
                               data_dirty_addr[LINE_OFF-1:0], data_replace_addr[LINE_OFF-1:0]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_edge
            assign edge_hit[gi] = req_in[gi] & ~req_q_reg[gi] & ~pend_reg[gi];
        end
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
            assign wr_word[gi] = dline_reg[cur_slot_reg[1]][gi*DATA_WIDTH +: DATA_WIDTH];
            assign rd_buf_next[gi*DATA_WIDTH +: DATA_WIDTH] =
                (beat_reg == BEAT_W'(gi)) ? mem.mem_rdata
                                          : rd_buf_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Writeback before fill inside a channel; rr_reg names the channel owed the next contested grant.
    assign inst_any = pend_reg[0] | pend_reg[1];
    assign data_any = pend_reg[2] | pend_reg[3];
    assign grant_ch = data_any & (~inst_any | rr_reg);
    assign grant_rd = grant_ch ? ~pend_reg[2] : ~pend_reg[0];
    assign last_ack = mem.mem_ack & (beat_reg == LAST_BEAT);

    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (inst_any | data_any) state_next = grant_rd ? RD : WR;
            WR, RD:  if (last_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem.mem_req           = (state_reg == WR) || (state_reg == RD);
        mem.mem_we            = (state_reg == WR);
        mem.mem_addr          = {addr_reg[cur_slot_reg], beat_reg, {WORD_OFF{1'b0}}};
        mem.mem_wdata         = wr_word[beat_reg];
        inst_mem_dirty_done   = (state_reg == DONE) && (cur_slot_reg == 2'd0);
        inst_mem_replace_done = (state_reg == DONE) && (cur_slot_reg == 2'd1);
        data_mem_dirty_done   = (state_reg == DONE) && (cur_slot_reg == 2'd2);
        data_mem_replace_done = (state_reg == DONE) && (cur_slot_reg == 2'd3);
    end

    // A slot's address/line only load on a fresh edge, so they stay frozen while it is queued or active.
    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            req_q_reg <= '0;
            pend_reg  <= '0;
            for (int i = 0; i < 4; i++) addr_reg[i] <= '0;
            dline_reg[0] <= '0;
            dline_reg[1] <= '0;
        end else begin
            req_q_reg <= req_in;
            for (int i = 0; i < 4; i++) begin
                if (state_reg == DONE && cur_slot_reg == 2'(i)) begin
                    pend_reg[i] <= 1'b0;
                end else if (edge_hit[i]) begin
                    pend_reg[i] <= 1'b1;
                    addr_reg[i] <= addr_in[i];
                end
            end
            if (edge_hit[0]) dline_reg[0] <= inst_dirty_line;
            if (edge_hit[2]) dline_reg[1] <= data_dirty_line;
        end
    end

    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            cur_slot_reg <= '0;
            rr_reg       <= 1'b0;
            beat_reg     <= '0;
            rd_buf_reg   <= '0;
            fill_line    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (inst_any | data_any) begin
                        cur_slot_reg <= {grant_ch, grant_rd};
                        if (inst_any & data_any) rr_reg <= ~grant_ch;
                    end
                end
                WR, RD: begin
                    if (mem.mem_ack) begin
                        if (state_reg == RD) rd_buf_reg <= rd_buf_next;
                        if (beat_reg != LAST_BEAT) begin
                            beat_reg <= beat_reg + 1'b1;
                        end else if (state_reg == RD) begin
                            // Publish on the last beat so the line is valid during the done pulse.
                            fill_line <= rd_buf_next;
                        end
                    end
                end
                DONE:    beat_reg <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_l2c_mem_bridge.sv
// Directed bench for l2c_mem_bridge: memory responder with configurable ack delay plus per-scenario checks.
module tb_l2c_mem_bridge;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 4;

    logic clk_l2 = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_l2 = ~clk_l2;

    logic          inst_mem_dirty_req = 1'b0, inst_mem_replace_req = 1'b0;
    logic          data_mem_dirty_req = 1'b0, data_mem_replace_req = 1'b0;
    logic [AW-1:0] inst_dirty_addr = '0, inst_replace_addr = '0;
    logic [AW-1:0] data_dirty_addr = '0, data_replace_addr = '0;
    logic [LW*DW-1:0] inst_dirty_line = '0, data_dirty_line = '0;
    logic          inst_mem_dirty_done, inst_mem_replace_done;
    logic          data_mem_dirty_done, data_mem_replace_done;
    logic [LW*DW-1:0] fill_line;

    l2c_mem_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    l2c_mem_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_WORDS(LW)) dut (
        .clk_l2               (clk_l2),
        .rst_n                (rst_n),
        .inst_mem_dirty_req   (inst_mem_dirty_req),
        .inst_mem_replace_req (inst_mem_replace_req),
        .inst_dirty_addr      (inst_dirty_addr),
        .inst_replace_addr    (inst_replace_addr),
        .inst_dirty_line      (inst_dirty_line),
        .inst_mem_dirty_done  (inst_mem_dirty_done),
        .inst_mem_replace_done(inst_mem_replace_done),
        .data_mem_dirty_req   (data_mem_dirty_req),
        .data_mem_replace_req (data_mem_replace_req),
        .data_dirty_addr      (data_dirty_addr),
        .data_replace_addr    (data_replace_addr),
        .data_dirty_line      (data_dirty_line),
        .data_mem_dirty_done  (data_mem_dirty_done),
        .data_mem_replace_done(data_mem_replace_done),
        .fill_line            (fill_line),
        .mem                  (bus)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            cyc;
    } beat_t;

    beat_t blog[$];
    int    done_order[$];
    int    done_cyc[$];
    logic [LW*DW-1:0] fill_seen = '0;
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    int    ack_delay = 0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    always @(posedge clk_l2) cyc <= cyc + 1;

    // Memory responder: ack tied high, or ack after ack_delay idle cycles of each beat.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk_l2); #1;
            if (ack_delay == 0) begin
                bus.mem_ack = 1'b1;
            end else if (bus.mem_req) begin
                if (wait_cnt == ack_delay) begin
                    bus.mem_ack = 1'b1;
                    wait_cnt = 0;
                end else begin
                    bus.mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.mem_ack = 1'b0;
                wait_cnt = 0;
            end
            bus.mem_rdata = mem_word(bus.mem_addr);
        end
    end

    always @(negedge clk_l2) begin
        if (bus.mem_req && bus.mem_ack) blog.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata, cyc});
        if (inst_mem_dirty_done)   begin done_order.push_back(0); done_cyc.push_back(cyc); end
        if (inst_mem_replace_done) begin done_order.push_back(1); done_cyc.push_back(cyc); end
        if (data_mem_dirty_done)   begin done_order.push_back(2); done_cyc.push_back(cyc); end
        if (data_mem_replace_done) begin done_order.push_back(3); done_cyc.push_back(cyc); end
        if (inst_mem_replace_done || data_mem_replace_done) fill_seen <= fill_line;
    end

    task automatic step();
        @(negedge clk_l2); #1;
    endtask

    task automatic drive_slot();
        @(posedge clk_l2); #1;
    endtask

    task automatic clear_logs();
        blog.delete();
        done_order.delete();
        done_cyc.delete();
    endtask

    task automatic wait_dones(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (done_order.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        total++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin bad++;
            $display("FAIL reset_bus: got we=%b addr=%h wdata=%h want 0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        total++; if ({inst_mem_dirty_done, inst_mem_replace_done, data_mem_dirty_done, data_mem_replace_done} !== 4'b0) begin bad++;
            $display("FAIL reset_done: got %b%b%b%b want 0000", inst_mem_dirty_done, inst_mem_replace_done, data_mem_dirty_done, data_mem_replace_done); end
        total++; if (fill_line !== '0) begin bad++; $display("FAIL reset_fill: got %h want 0", fill_line); end
        @(posedge clk_l2); #2;
        rst_n = 1'b1;
        repeat (3) step();
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_release_idle: got %b want 0", bus.mem_req); end
    endtask

    task automatic test_inst_fill();
        logic [LW*DW-1:0] exp_fill;
        int c0;
        bit ok;
        for (int k = 0; k < LW; k++) exp_fill[k*DW +: DW] = mem_word(32'h1000 + 32'(4*k));
        clear_logs();
        drive_slot();
        inst_replace_addr = 32'h0000_1004;
        inst_mem_replace_req = 1'b1;
        c0 = cyc;
        drive_slot();
        inst_mem_replace_req = 1'b0;
        step();
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL fill_req_t1: got %b want 0", bus.mem_req); end
        step();
        total++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h1000) begin bad++;
            $display("FAIL fill_req_t2: got req=%b we=%b addr=%h want 1 0 00001000", bus.mem_req, bus.mem_we, bus.mem_addr); end
        wait_dones(1, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL fill_timeout: got no done want 1 done"); end
        total++; if (blog.size() != 4) begin bad++; $display("FAIL fill_beats: got %0d want 4", blog.size()); end
        for (int k = 0; k < blog.size() && k < 4; k++) begin
            total++; if (blog[k].we !== 1'b0 || blog[k].addr !== 32'h1000 + 32'(4*k)) begin bad++;
                $display("FAIL fill_beat%0d: got we=%b addr=%h want 0 %h", k, blog[k].we, blog[k].addr, 32'h1000 + 32'(4*k)); end
        end
        total++; if (done_order.size() < 1 || done_order[0] != 1 || done_cyc[0] != c0 + 6) begin bad++;
            $display("FAIL fill_done: got n=%0d kind=%0d cyc=%0d want 1 1 %0d", done_order.size(),
                     done_order.size() > 0 ? done_order[0] : -1, done_cyc.size() > 0 ? done_cyc[0] : -1, c0 + 6); end
        total++; if (fill_seen !== exp_fill) begin bad++; $display("FAIL fill_line: got %h want %h", fill_seen, exp_fill); end
        repeat (5) step();
        total++; if (done_order.size() != 1 || fill_line !== exp_fill) begin bad++;
            $display("FAIL fill_hold: got dones=%0d fill=%h want 1 %h", done_order.size(), fill_line, exp_fill); end
    endtask

    task automatic test_data_wb_level();
        logic [DW-1:0] wexp [4];
        bit ok;
        wexp = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
        clear_logs();
        drive_slot();
        data_dirty_addr = 32'h0000_2000;
        data_dirty_line = {wexp[3], wexp[2], wexp[1], wexp[0]};
        data_mem_dirty_req = 1'b1;
        wait_dones(1, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL wb_timeout: got no done want 1 done"); end
        repeat (3) drive_slot();
        data_mem_dirty_req = 1'b0;
        repeat (10) step();
        total++; if (blog.size() != 4) begin bad++; $display("FAIL wb_beats: got %0d want 4", blog.size()); end
        for (int k = 0; k < blog.size() && k < 4; k++) begin
            total++; if (blog[k].we !== 1'b1 || blog[k].addr !== 32'h2000 + 32'(4*k) || blog[k].wdata !== wexp[k]) begin bad++;
                $display("FAIL wb_beat%0d: got we=%b addr=%h wdata=%h want 1 %h %h", k, blog[k].we, blog[k].addr,
                         blog[k].wdata, 32'h2000 + 32'(4*k), wexp[k]); end
        end
        total++; if (done_order.size() != 1 || done_order[0] != 2) begin bad++;
            $display("FAIL wb_single_done: got n=%0d want 1 data dirty done", done_order.size()); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL wb_idle_after: got %b want 0", bus.mem_req); end
    endtask

    task automatic test_rr_arbitration();
        logic [LW*DW-1:0] exp_fill;
        bit ok;
        for (int k = 0; k < LW; k++) exp_fill[k*DW +: DW] = mem_word(32'h4000 + 32'(4*k));
        clear_logs();
        drive_slot();
        inst_replace_addr = 32'h3000; data_replace_addr = 32'h4000;
        inst_mem_replace_req = 1'b1; data_mem_replace_req = 1'b1;
        drive_slot();
        inst_mem_replace_req = 1'b0; data_mem_replace_req = 1'b0;
        wait_dones(2, 40, ok);
        total++; if (!ok || blog.size() != 8) begin bad++; $display("FAIL rr1_complete: got beats=%0d want 8", blog.size()); end
        total++; if (blog.size() == 8 && (blog[0].addr !== 32'h3000 || blog[4].addr !== 32'h4000)) begin bad++;
            $display("FAIL rr1_order: got %h,%h want 00003000,00004000", blog[0].addr, blog[4].addr); end
        total++; if (done_order.size() != 2 || done_order[0] != 1 || done_order[1] != 3) begin bad++;
            $display("FAIL rr1_done_order: got n=%0d want inst then data", done_order.size()); end
        total++; if (fill_seen !== exp_fill) begin bad++; $display("FAIL rr1_fill: got %h want %h", fill_seen, exp_fill); end
        clear_logs();
        drive_slot();
        inst_replace_addr = 32'h5000; data_replace_addr = 32'h6000;
        inst_mem_replace_req = 1'b1; data_mem_replace_req = 1'b1;
        drive_slot();
        inst_mem_replace_req = 1'b0; data_mem_replace_req = 1'b0;
        wait_dones(2, 40, ok);
        total++; if (!ok || blog.size() != 8) begin bad++; $display("FAIL rr2_complete: got beats=%0d want 8", blog.size()); end
        total++; if (blog.size() == 8 && (blog[0].addr !== 32'h6000 || blog[4].addr !== 32'h5000)) begin bad++;
            $display("FAIL rr2_order: got %h,%h want 00006000,00005000", blog[0].addr, blog[4].addr); end
        total++; if (done_order.size() != 2 || done_order[0] != 3 || done_order[1] != 1) begin bad++;
            $display("FAIL rr2_done_order: got n=%0d want data then inst", done_order.size()); end
    endtask

    task automatic test_ack_wait();
        logic [DW-1:0] wexp [4];
        int c0, nb, unstable;
        bit ok;
        wexp = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
        ack_delay = 3;
        repeat (2) step();
        clear_logs();
        drive_slot();
        inst_dirty_addr = 32'h7008;
        inst_dirty_line = {wexp[3], wexp[2], wexp[1], wexp[0]};
        inst_mem_dirty_req = 1'b1;
        c0 = cyc;
        drive_slot();
        inst_mem_dirty_req = 1'b0;
        unstable = 0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (done_order.size() >= 1) begin ok = 1'b1; break; end
            if (bus.mem_req) begin
                nb = blog.size() - (bus.mem_ack ? 1 : 0);
                if (nb > 3 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h7000 + 32'(4*nb) || bus.mem_wdata !== wexp[nb])
                    unstable++;
            end
        end
        total++; if (!ok) begin bad++; $display("FAIL wait_timeout: got no done want 1 done"); end
        total++; if (unstable != 0) begin bad++; $display("FAIL wait_stable: got %0d bad cycles want 0", unstable); end
        total++; if (blog.size() != 4) begin bad++; $display("FAIL wait_beats: got %0d want 4", blog.size()); end
        total++; if (blog.size() == 4 && (done_cyc[0] != blog[3].cyc + 1 || done_cyc[0] != c0 + 18)) begin bad++;
            $display("FAIL wait_done_cyc: got %0d want %0d", done_cyc[0], c0 + 18); end
        ack_delay = 0;
    endtask

    task automatic test_reset_abort();
        int reqs;
        bit reached;
        ack_delay = 2;
        repeat (2) step();
        clear_logs();
        drive_slot();
        data_dirty_addr = 32'h2400;
        data_dirty_line = {32'h4, 32'h3, 32'h2, 32'h1};
        data_mem_dirty_req = 1'b1;
        drive_slot();
        data_mem_dirty_req = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (blog.size() == 2 && bus.mem_req && !bus.mem_ack) begin reached = 1'b1; break; end
        end
        total++; if (!reached) begin bad++; $display("FAIL abort_reach_beat2: got beats=%0d want 2 with req waiting", blog.size()); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL abort_async_req: got %b want 0", bus.mem_req); end
        repeat (2) step();
        rst_n = 1'b1;
        ack_delay = 0;
        reqs = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.mem_req) reqs++;
        end
        total++; if (reqs != 0 || blog.size() != 2) begin bad++;
            $display("FAIL abort_idle: got req_cycles=%0d beats=%0d want 0 2", reqs, blog.size()); end
        total++; if (done_order.size() != 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", done_order.size()); end
    endtask

    task automatic test_queue_order();
        logic [LW*DW-1:0] exp_fill;
        bit ok, seen;
        for (int k = 0; k < LW; k++) exp_fill[k*DW +: DW] = mem_word(32'hA000 + 32'(4*k));
        clear_logs();
        drive_slot();
        inst_replace_addr = 32'h8000;
        inst_mem_replace_req = 1'b1;
        drive_slot();
        inst_mem_replace_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.mem_req) begin seen = 1'b1; break; end
        end
        total++; if (!seen) begin bad++; $display("FAIL queue_inst_start: got no mem_req want mem_req"); end
        drive_slot();
        data_dirty_addr = 32'h9000;
        data_dirty_line = {32'h9D, 32'h9C, 32'h9B, 32'h9A};
        data_mem_dirty_req = 1'b1;
        drive_slot();
        data_mem_dirty_req = 1'b0;
        data_replace_addr = 32'hA000;
        data_mem_replace_req = 1'b1;
        drive_slot();
        data_mem_replace_req = 1'b0;
        wait_dones(3, 60, ok);
        total++; if (!ok || done_order.size() != 3 || done_order[0] != 1 || done_order[1] != 2 || done_order[2] != 3) begin bad++;
            $display("FAIL queue_done_order: got n=%0d want inst RD, data WR, data RD", done_order.size()); end
        total++; if (blog.size() != 12) begin bad++; $display("FAIL queue_beats: got %0d want 12", blog.size()); end
        total++; if (blog.size() == 12 && (blog[0].addr !== 32'h8000 || blog[0].we !== 1'b0 ||
                                           blog[4].addr !== 32'h9000 || blog[4].we !== 1'b1 || blog[4].wdata !== 32'h9A ||
                                           blog[8].addr !== 32'hA000 || blog[8].we !== 1'b0)) begin bad++;
            $display("FAIL queue_bursts: got %h/%b %h/%b/%h %h/%b want 8000/0 9000/1/9A A000/0",
                     blog[0].addr, blog[0].we, blog[4].addr, blog[4].we, blog[4].wdata, blog[8].addr, blog[8].we); end
        total++; if (fill_seen !== exp_fill) begin bad++; $display("FAIL queue_fill: got %h want %h", fill_seen, exp_fill); end
    endtask

    initial begin
        test_reset();
        test_inst_fill();
        test_data_wb_level();
        test_rr_arbitration();
        test_ack_wait();
        test_reset_abort();
        test_queue_order();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
